fibo_controller_n: RTL and testbench
====================================

Name: fibo_controller_n

Overview:
- Control FSM that sits directly upstream of the Fibonacci datapath (4-entry register file, ALU, zero flag).
- Drives the datapath's write address, write enable, load select, both read addresses, ALU opcode and count inputs, and consumes its zero_flag and data.
- Sequences the datapath to compute Fib(n), with Fib(0)=0 and Fib(1)=1, modulo 2^size.
- Captures the final value and reports completion with a one-cycle done pulse.

Parameters:
- size, 4, datapath word width; applies to n, count, data and result.
- OP_PASS, 3'b000, ALU opcode that outputs operand A.
- OP_ADD, 3'b001, ALU opcode that outputs A+B, truncated to size bits.
- OP_DEC, 3'b100, ALU opcode that outputs A-1, truncated to size bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a computation; sampled only in IDLE.
- n  input  size  Fibonacci index; captured into n_q on the accepted start.
- zero_flag  input  1  datapath ALU zero flag; combinational from the current read addresses and opcode.
- data  input  size  datapath ALU result; combinational.
- wrt_addr  output  2  register-file write address.
- wrt_en  output  1  register-file write enable; the write occurs at the rising edge.
- load_data  output  1  write-data select: 1 writes count, 0 writes the ALU result.
- rd_addr1  output  2  ALU operand A register select.
- rd_addr2  output  2  ALU operand B register select.
- alu_opcode  output  3  ALU operation.
- count  output  size  constant or immediate value written when load_data=1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when result is valid.
- result  output  size  registered Fib(n) mod 2^size; holds its value until the next DONE.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Register map:
  - R0 = remaining iteration count
  - R1 = a
  - R2 = b
  - R3 = temp
- Moore outputs are decoded from the state. In any state not listed below, all of the following are 0: wrt_en, load_data, wrt_addr, rd_addr1, rd_addr2, count; alu_opcode = OP_PASS.
- States and actions:
  - IDLE: no writes. If start=1, capture n_q<=n and go to INIT_N.
  - INIT_N: load_data=1, count=n_q, wrt_en=1, wrt_addr=0. Go to INIT_A.
  - INIT_A: load_data=1, count=0, wrt_en=1, wrt_addr=1. Go to INIT_B.
  - INIT_B: load_data=1, count=1, wrt_en=1, wrt_addr=2. Go to CHECK.
  - CHECK: rd_addr1=0, alu_opcode=OP_PASS, no write. If zero_flag=1, go to DONE; otherwise go to ADD.
  - ADD: rd_addr1=1, rd_addr2=2, alu_opcode=OP_ADD, load_data=0, wrt_en=1, wrt_addr=3. Go to MOV1.
  - MOV1: rd_addr1=2, alu_opcode=OP_PASS, wrt_en=1, wrt_addr=1. Go to MOV2.
  - MOV2: rd_addr1=3, alu_opcode=OP_PASS, wrt_en=1, wrt_addr=2. Go to DEC.
  - DEC: rd_addr1=0, alu_opcode=OP_DEC, wrt_en=1, wrt_addr=0. Go to CHECK.
  - DONE: rd_addr1=1, alu_opcode=OP_PASS, result<=data, done=1. Go to IDLE.
- Latency: if start is sampled at edge k, done is high during cycle k+5+5*n_q. The result register updates at the edge ending DONE and is stable from cycle k+6+5*n_q.
- Arithmetic wraps modulo 2^size; overflow is not flagged.
- start in any state other than IDLE is ignored; no queuing.
- start held high through DONE is accepted again in the following IDLE cycle. Back-to-back operations therefore have one IDLE cycle between them.
- n changing while busy=1 has no effect, because n_q is used.
- n_q = 2^size-1 is legal: the block runs the full loop count and does not guard against it.
- Reset, including mid-operation:
  - next state is IDLE
  - result=0, n_q=0, done=0, busy=0
  - all control outputs take their IDLE values
  - register-file contents are don't-care; the datapath has no reset and the controller always reinitialises R0..R2 before use.
- Register-file writes are committed only through wrt_en at clk edges. The controller never asserts wrt_en in IDLE or DONE.

Test Plan:
- Reset: assert rst for 2 cycles from unknown state -> busy=0, done=0, result=0, wrt_en=0; rst mid-loop (n=6, cycle 12) -> IDLE next cycle, no done pulse.
- n=0, start pulse at edge k -> done high only in cycle k+5, result=0.
- n=1 -> done in cycle k+10, result=1; n=6 -> done in cycle k+35, result=8.
- size=4, n=8 -> result=21 mod 16=5 (wrap); n=7 -> result=13.
- start re-pulsed at cycles k+3 and k+20 during n=6 run -> ignored, exactly one done, result=8; n changed to 2 mid-run -> result still 8.
- Back-to-back: start held high, n=2 then n=3 -> done pulses with result=1 then 2, separated by one IDLE cycle; per-state wrt_addr/opcode sequence checked against the table above via a datapath model.

Source files
------------

// File: rtl/fibo_controller_n.sv
// Control FSM for the Fibonacci datapath: sequences register-file writes and ALU
// operations to compute Fib(n) mod 2^size, then reports it with a done pulse.
module fibo_controller_n #(
  parameter int         size    = 4,
  parameter logic [2:0] OP_PASS = 3'b000,
  parameter logic [2:0] OP_ADD  = 3'b001,
  parameter logic [2:0] OP_DEC  = 3'b100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] n,
  input  logic            zero_flag,
  input  logic [size-1:0] data,
  output logic [1:0]      wrt_addr,
  output logic            wrt_en,
  output logic            load_data,
  output logic [1:0]      rd_addr1,
  output logic [1:0]      rd_addr2,
  output logic [2:0]      alu_opcode,
  output logic [size-1:0] count,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] result
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_N,
    S_INIT_A,
    S_INIT_B,
    S_CHECK,
    S_ADD,
    S_MOV1,
    S_MOV2,
    S_DEC,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [size-1:0] n_q;
  logic [size-1:0] result_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) n_q <= n;
      if (state_q == S_DONE) result_q <= data;
    end
  end

  assign result = result_q;

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    wrt_en     = 1'b0;
    wrt_addr   = 2'd0;
    load_data  = 1'b0;
    rd_addr1   = 2'd0;
    rd_addr2   = 2'd0;
    alu_opcode = OP_PASS;
    count      = '0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT_N;
      end
      S_INIT_N: begin
        load_data = 1'b1;
        count     = n_q;
        wrt_en    = 1'b1;
        wrt_addr  = 2'd0;
        state_d   = S_INIT_A;
      end
      S_INIT_A: begin
        load_data = 1'b1;
        count     = '0;
        wrt_en    = 1'b1;
        wrt_addr  = 2'd1;
        state_d   = S_INIT_B;
      end
      S_INIT_B: begin
        load_data = 1'b1;
        count     = size'(1);
        wrt_en    = 1'b1;
        wrt_addr  = 2'd2;
        state_d   = S_CHECK;
      end
      S_CHECK: begin
        rd_addr1   = 2'd0;
        alu_opcode = OP_PASS;
        state_d    = zero_flag ? S_DONE : S_ADD;
      end
      S_ADD: begin
        rd_addr1   = 2'd1;
        rd_addr2   = 2'd2;
        alu_opcode = OP_ADD;
        wrt_en     = 1'b1;
        wrt_addr   = 2'd3;
        state_d    = S_MOV1;
      end
      // Shift the pair: a <= b, b <= temp.
      S_MOV1: begin
        rd_addr1   = 2'd2;
        alu_opcode = OP_PASS;
        wrt_en     = 1'b1;
        wrt_addr   = 2'd1;
        state_d    = S_MOV2;
      end
      S_MOV2: begin
        rd_addr1   = 2'd3;
        alu_opcode = OP_PASS;
        wrt_en     = 1'b1;
        wrt_addr   = 2'd2;
        state_d    = S_DEC;
      end
      S_DEC: begin
        rd_addr1   = 2'd0;
        alu_opcode = OP_DEC;
        wrt_en     = 1'b1;
        wrt_addr   = 2'd0;
        state_d    = S_CHECK;
      end
      S_DONE: begin
        rd_addr1   = 2'd1;
        alu_opcode = OP_PASS;
        done       = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fibo_controller_n.sv
// Bench for fibo_controller_n: drives it through a model of the Fibonacci
// datapath and checks results, latency and per-cycle control outputs.
module tb_fibo_controller_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] n_in;
  logic       zero_flag;
  logic [3:0] data;
  logic [1:0] wrt_addr;
  logic       wrt_en;
  logic       load_data;
  logic [1:0] rd_addr1;
  logic [1:0] rd_addr2;
  logic [2:0] alu_opcode;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic [3:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fibo_controller_n #(.size(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n         (n_in),
    .zero_flag (zero_flag),
    .data      (data),
    .wrt_addr  (wrt_addr),
    .wrt_en    (wrt_en),
    .load_data (load_data),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .alu_opcode(alu_opcode),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  // Datapath model: 4-entry register file without reset, combinational ALU.
  logic [3:0] rf [4];
  logic [3:0] opa, opb;

  always_comb begin
    opa = rf[rd_addr1];
    opb = rf[rd_addr2];
    case (alu_opcode)
      3'b001:  data = opa + opb;
      3'b100:  data = opa - 4'd1;
      default: data = opa;
    endcase
    zero_flag = (data == 4'd0);
  end

  always @(posedge clk) if (wrt_en) rf[wrt_addr] <= load_data ? count : data;

  typedef struct packed {
    logic       wrt_en;
    logic [1:0] wrt_addr;
    logic       load_data;
    logic [1:0] rd1;
    logic [1:0] rd2;
    logic [2:0] op;
    logic [3:0] count;
    logic       busy;
    logic       done;
  } ctl_t;

  ctl_t ctl_act;
  assign ctl_act = '{wrt_en, wrt_addr, load_data, rd_addr1, rd_addr2,
                     alu_opcode, count, busy, done};

  typedef struct {
    int         n;
    logic [3:0] exp_res;
    int         exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] fib_ref(input int nv);
    int a = 0;
    int b = 1;
    int t;
    for (int i = 0; i < nv; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return 4'(a % 16);
  endfunction

  // Expected Moore outputs per state: 0 INIT_N .. 8 DONE, anything else IDLE.
  function automatic ctl_t exp_ctl(input int kind, input int nv);
    ctl_t c;
    c = '0;
    c.busy = 1'b1;
    case (kind)
      0: begin c.load_data = 1; c.count = 4'(nv); c.wrt_en = 1; c.wrt_addr = 2'd0; end
      1: begin c.load_data = 1; c.count = 4'd0;   c.wrt_en = 1; c.wrt_addr = 2'd1; end
      2: begin c.load_data = 1; c.count = 4'd1;   c.wrt_en = 1; c.wrt_addr = 2'd2; end
      3: begin c.rd1 = 2'd0; c.op = 3'b000; end
      4: begin c.rd1 = 2'd1; c.rd2 = 2'd2; c.op = 3'b001; c.wrt_en = 1; c.wrt_addr = 2'd3; end
      5: begin c.rd1 = 2'd2; c.wrt_en = 1; c.wrt_addr = 2'd1; end
      6: begin c.rd1 = 2'd3; c.wrt_en = 1; c.wrt_addr = 2'd2; end
      7: begin c.rd1 = 2'd0; c.op = 3'b100; c.wrt_en = 1; c.wrt_addr = 2'd0; end
      8: begin c.rd1 = 2'd1; c.done = 1; end
      default: c.busy = 1'b0;
    endcase
    return c;
  endfunction

  // One operation from IDLE. start is re-pulsed in cycles ra/rb and n is
  // changed to nnew in cycle nc (0 disables); neither may affect the run.
  task automatic do_run(input int nv, input int ra, input int rb, input int nc,
                        input int nnew, output int lat, output logic [3:0] res);
    int steps[$];
    steps = '{0, 1, 2};
    for (int i = 0; i < nv; i++) steps = {steps, 3, 4, 5, 6, 7};
    steps = {steps, 3, 8};
    @(negedge clk);
    n_in  = 4'(nv);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c <= steps.size()) check("ctl_seq", 32'(ctl_act), 32'(exp_ctl(steps[c-1], nv)));
      start = (c == ra || c == rb);
      if (nc != 0 && c == nc) n_in = 4'(nnew);
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("done_width", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    res = result;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    int         lat;
    logic [3:0] res;
    int         nv;
    bit         seen_done;

    vecs[0] = '{0, 4'd0,  5};
    vecs[1] = '{1, 4'd1,  10};
    vecs[2] = '{6, 4'd8,  35};
    vecs[3] = '{7, 4'd13, 40};
    vecs[4] = '{8, 4'd5,  45};
    vecs[5] = '{15, 4'd2, 80};

    rst   = 1'b1;
    start = 1'b0;
    n_in  = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ctl", 32'(ctl_act), 32'(exp_ctl(-1, 0)));
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_run(vecs[i].n, 0, 0, 0, 0, lat, res);
      check("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
      check("vec_result", 32'(res), 32'(vecs[i].exp_res));
    end

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      nv = int'($urandom_range(0, 15));
      do_run(nv, 0, 0, 0, 0, lat, res);
      check("rand_latency", 32'(lat), 32'(5 + 5 * nv));
      check("rand_result", 32'(res), 32'(fib_ref(nv)));
    end

    // Busy-time start pulses and an n change are ignored.
    do_run(6, 3, 20, 8, 2, lat, res);
    check("ign_latency", 32'(lat), 32'd35);
    check("ign_result", 32'(res), 32'd8);

    // Back-to-back with start held: one IDLE cycle between operations.
    @(negedge clk);
    n_in  = 4'd2;
    start = 1'b1;
    @(posedge clk);
    wait_done(200, lat);
    check("b2b_lat1", 32'(lat), 32'd15);
    n_in = 4'd3;
    @(negedge clk);
    check("b2b_idle_busy", 32'(busy), 32'd0);
    check("b2b_res1", 32'(result), 32'd1);
    @(negedge clk);
    check("b2b_restart", 32'(ctl_act), 32'(exp_ctl(0, 3)));
    start = 1'b0;
    wait_done(200, lat);
    check("b2b_lat2", 32'(lat), 32'd19);
    @(negedge clk);
    check("b2b_res2", 32'(result), 32'd2);

    // Reset in the middle of an n=6 run.
    @(negedge clk);
    n_in  = 4'd6;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_ctl", 32'(ctl_act), 32'(exp_ctl(-1, 0)));
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("mid_rst_quiet", 32'(seen_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
